// File: rtl/timebase_pkg.sv
// Shared definitions for the timebase family: direction encoding and the
// divider arithmetic that timed blocks use to turn a clock rate into a tick rate.
package timebase_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  function automatic int calc_div(input int clk_freq, input int tick_hz);
    return clk_freq / tick_hz;
  endfunction

endpackage

// File: rtl/timebase_counter_tick_prescaler.sv
// Free-running 0..DIV-1 divider; terminal flags the last cycle of each period.
module tick_prescaler
  import timebase_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic terminal
);

  localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign terminal = (presc_q == TERM);

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      // >= also recovers a corrupted value above the terminal in non-power-of-2 dividers
      presc_d = (presc_q >= TERM) ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/timebase_counter.sv
// Modulo timebase counter over [CNT_MIN, CNT_MAX] advanced once per prescaler
// period, with load, pause, direction and registered tick/wrap flags.
module timebase_counter
  import timebase_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int TICK_HZ  = 1,
  parameter int CNT_W    = 7,
  parameter int CNT_MIN  = 1,
  parameter int CNT_MAX  = 90
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] cmp_val,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             match
);

  localparam int DIV = calc_div(CLK_FREQ, TICK_HZ);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("timebase_counter: CLK_FREQ/TICK_HZ must be at least 2");
    end
    if (!(CNT_MIN < CNT_MAX) || (CNT_MAX >= (2 ** CNT_W))) begin : g_bad_range
      $error("timebase_counter: need CNT_MIN < CNT_MAX < 2**CNT_W");
    end
  endgenerate

  logic             terminal;
  logic             advance;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (load),
    .terminal(terminal)
  );

  // A load on a terminal edge discards that advance.
  assign advance = en && terminal && !load;

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = ((load_val >= MIN_V) && (load_val <= MAX_V)) ? load_val : MIN_V;
    end else if (advance) begin
      tick_d = 1'b1;
      if ((count_q < MIN_V) || (count_q > MAX_V)) begin
        count_d = MIN_V;
      end else if (dir == DIR_UP) begin
        if (count_q == MAX_V) begin
          count_d = MIN_V;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == MIN_V) begin
          count_d = MAX_V;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= MIN_V;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign match = (count_q == cmp_val);

endmodule

// File: doc/timebase_counter.md
Name: timebase_counter

Overview:
Parametrised seconds/timebase counter for the FSM driver set. A prescaler divides the system clock down to a tick rate, and a modulo counter advances once per tick over a configurable range [CNT_MIN, CNT_MAX]. Count direction is selectable (up/down), the count can be loaded and paused, and the block emits tick, wrap and compare-match flags. It is the timing source for the display and sequencing FSMs.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
TICK_HZ, 1, tick rate in Hz; DIV = CLK_FREQ/TICK_HZ, must be >= 2 (elaboration error otherwise)
CNT_W, 7, width of the count and related ports
CNT_MIN, 1, lowest count value
CNT_MAX, 90, highest count value; requires CNT_MIN < CNT_MAX < 2**CNT_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  run enable; low freezes the prescaler and count
dir  in  1  0 = count up, 1 = count down
load  in  1  one-cycle load strobe
load_val  in  CNT_W  value applied on load
cmp_val  in  CNT_W  compare value for match
count  out  CNT_W  current count
tick  out  1  one-cycle pulse when count advances
wrap  out  1  one-cycle pulse when count wraps
match  out  1  level, count == cmp_val

Behaviour:
- Reset (rst=1 at a clk edge): prescaler=0, count=CNT_MIN, tick=0, wrap=0. match is combinational from count and cmp_val. rst overrides all other inputs.
- Prescaler width is clog2(DIV). It counts 0..DIV-1 while en=1. Terminal occurs at DIV-1, giving exactly DIV cycles per tick. On terminal it returns to 0.
- Advance happens on an edge where en=1 and prescaler==DIV-1:
  - up: count==CNT_MAX -> CNT_MIN with wrap; otherwise count+1.
  - down: count==CNT_MIN -> CNT_MAX with wrap; otherwise count-1.
- tick and wrap are registered. They are high for exactly the one cycle in which the new count value is first visible. wrap implies tick.
- dir is sampled only at the advance edge. Changing dir between ticks has no other effect.
- en=0: prescaler and count hold, tick=wrap=0. Resuming continues from the held prescaler value, with no extra or lost cycles.
- load=1 (any en): count <= load_val if CNT_MIN <= load_val <= CNT_MAX, else CNT_MIN. The prescaler clears to 0 and tick=wrap=0 that cycle. The next tick comes DIV enabled cycles later.
- load coincident with a prescaler terminal: load wins and the advance is discarded.
- Count outside the range cannot occur. If it ever does (SEU), the next advance forces CNT_MIN.
- Latency: load -> count 1 cycle. Terminal edge -> tick/count 1 cycle (both registered at the same edge).
- No internal arithmetic overflow: the up increment is never applied at CNT_MAX, so CNT_MAX may equal 2**CNT_W-1.

Decomposition:
- Package timebase_pkg:
  - DIR_UP/DIR_DOWN constants
  - clog2 helper function
  - the DIV calculation function shared by other timed blocks
- One sub-module, tick_prescaler (params DIV):
  - inputs clk, rst, en, clr
  - output terminal (combinational, prescaler==DIV-1)
- The counter/flag logic stays in timebase_counter.

Test Plan:
All scenarios use CLK_FREQ=10, TICK_HZ=1 (DIV=10), CNT_MIN=1, CNT_MAX=5, CNT_W=3.
1. Reset then en=1, dir=0 for 60 cycles -> count 1,2,3,4,5,1 changing every 10 cycles. tick is one cycle wide at each change. wrap is high only on the 5->1 change.
2. dir=1 from count=2 -> count 2,1,5,4 at 10-cycle spacing. wrap pulses on 1->5.
3. en dropped for 7 cycles, 4 cycles after a tick -> the next tick comes 17 cycles after the previous one, with count unchanged while paused.
4. load=1, load_val=4 on the same edge as a prescaler terminal -> count=4 next cycle, no tick that cycle, next tick 10 cycles later (count=5). A second load with load_val=7 gives count=1.
5. cmp_val=3 -> match high exactly during the count==3 interval. Changing cmp_val to 4 mid-interval drops match the same cycle.
6. rst asserted mid-count (count=4, prescaler=6), together with load=1 -> the next cycle shows count=1, tick=wrap=0, and the first tick 10 cycles after rst deasserts.
